// File: rtl/setting_arb_pkg.sv
// Shared types and width helpers for the settings-bus arbiter.
package setting_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_t;

    localparam int DATA_W = 32;
    localparam int WDOG_W = 16;

    function automatic int src_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int beat_w(input int awidth);
        return awidth + DATA_W;
    endfunction

endpackage

// File: rtl/setting_bus_arbiter_if.sv
// Command-source streams and the shared settings bus, as seen by the arbiter (master)
// and by the sources/register fan-out (slave).
interface setting_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 8
);
    import setting_arb_pkg::*;

    localparam int SRC_W  = src_w(NUM_REQ);
    localparam int BEAT_W = beat_w(AWIDTH);

    logic [NUM_REQ*BEAT_W-1:0] i_tdata;
    logic [NUM_REQ-1:0]        i_tlast;
    logic [NUM_REQ-1:0]        i_tvalid;
    logic [NUM_REQ-1:0]        i_tready;
    logic                      set_stb;
    logic [AWIDTH-1:0]         set_addr;
    logic [DATA_W-1:0]         set_data;
    logic [SRC_W-1:0]          set_src;

    modport master (
        input  i_tdata, i_tlast, i_tvalid,
        output i_tready, set_stb, set_addr, set_data, set_src
    );

    modport slave (
        output i_tdata, i_tlast, i_tvalid,
        input  i_tready, set_stb, set_addr, set_data, set_src
    );

endinterface

// File: rtl/setting_arb_rr_pick.sv
// Combinational round-robin picker: first requester after rr_ptr_i, wrapping modulo NUM_REQ.
module setting_arb_rr_pick
    import setting_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int SRC_W  = src_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SRC_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [SRC_W-1:0]   grant_idx_o,
    output logic               any_req_o
);

    logic             found;
    logic [SRC_W-1:0] idx;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_req_o   = |req_i;
        found       = 1'b0;
        idx         = '0;
        // i = NUM_REQ lands on rr_ptr itself, so the last owner is the lowest priority
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = SRC_W'((int'(rr_ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found            = 1'b1;
                grant_idx_o      = idx;
                grant_oh_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/setting_bus_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one settings bus between NUM_REQ command streams.
// Optional lock watchdog compiled in with SETTING_ARB_WATCHDOG_EN.
module setting_bus_arbiter
    import setting_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    setting_bus_arbiter_if.master bus,
    output logic                  busy,
    output logic                  timeout_stb
);

    localparam int SRC_W  = src_w(NUM_REQ);
    localparam int BEAT_W = beat_w(AWIDTH);

    arb_state_t        state_q, state_d;
    logic [SRC_W-1:0]  owner_q, owner_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              set_stb_q;
    logic [AWIDTH-1:0] set_addr_q;
    logic [DATA_W-1:0] set_data_q;
    logic [SRC_W-1:0]  set_src_q;

    logic [NUM_REQ-1:0] grant_oh;
    logic [SRC_W-1:0]   grant_idx;
    logic               any_req;
    logic               accept;
    logic [SRC_W-1:0]   accept_idx;
    logic [NUM_REQ-1:0] tready;
    logic [BEAT_W-1:0]  beat [NUM_REQ];
    logic [BEAT_W-1:0]  sel_beat;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_beat
            assign beat[gi] = bus.i_tdata[gi*BEAT_W +: BEAT_W];
        end
    endgenerate

    setting_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i       (bus.i_tvalid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .any_req_o   (any_req)
    );

`ifdef SETTING_ARB_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              tmo_q, tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tready     = '0;
        accept     = 1'b0;
        accept_idx = owner_q;
`ifdef SETTING_ARB_WATCHDOG_EN
        wdog_d     = wdog_q;
        tmo_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef SETTING_ARB_WATCHDOG_EN
                wdog_d = '0;
`endif
                if (any_req) begin
                    tready     = grant_oh;
                    accept     = 1'b1;
                    accept_idx = grant_idx;
                    rr_ptr_d   = grant_idx;
                    if (!bus.i_tlast[grant_idx]) begin
                        owner_d = grant_idx;
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                tready[owner_q] = 1'b1;
                if (bus.i_tvalid[owner_q]) begin
                    accept     = 1'b1;
                    accept_idx = owner_q;
`ifdef SETTING_ARB_WATCHDOG_EN
                    wdog_d     = '0;
`endif
                    // rr_ptr already points at the owner, so the next grant starts after it
                    if (bus.i_tlast[owner_q]) begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef SETTING_ARB_WATCHDOG_EN
                else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    wdog_d  = '0;
                    tmo_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel_beat = beat[accept_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= SRC_W'(NUM_REQ - 1);
            set_stb_q  <= 1'b0;
            set_addr_q <= '0;
            set_data_q <= '0;
            set_src_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            set_stb_q <= accept;
            if (accept) begin
                set_addr_q <= sel_beat[BEAT_W-1 -: AWIDTH];
                set_data_q <= sel_beat[DATA_W-1:0];
                set_src_q  <= accept_idx;
            end
        end
    end

`ifdef SETTING_ARB_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout_stb = tmo_q;
`else
    // No watchdog: constant 0 for every legal TIMEOUT
    assign timeout_stb = (TIMEOUT > 65535);
`endif

    assign bus.i_tready = tready;
    assign bus.set_stb  = set_stb_q;
    assign bus.set_addr = set_addr_q;
    assign bus.set_data = set_data_q;
    assign bus.set_src  = set_src_q;
    assign busy         = (state_q == ST_LOCKED);

endmodule

// File: doc/setting_bus_arbiter.md
# setting_bus_arbiter

Shares one settings bus (set_stb/set_addr/set_data) between NUM_REQ AXI-stream command sources, such as host control, a CPU and autonomous sequencers. Arbitration is round-robin, and a grant is held for a whole packet (tlast), so multi-word writes stay atomic. This matters for STROBE_LAST/ADDR_LAST register pairs. The block sits between the command sources and the settings-register fan-out, one write per cycle at most.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- AWIDTH, 8: settings address width.
- TIMEOUT, 255: idle cycles before a locked owner's grant is revoked. Used only with the watchdog compiled in; 1..65535.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- i_tdata  in  NUM_REQ*(AWIDTH+32): requester k at bits [k*(AWIDTH+32) +: AWIDTH+32]; upper AWIDTH bits = address, lower 32 = data.
- i_tlast  in  NUM_REQ  per-requester end of packet.
- i_tvalid  in  NUM_REQ  per-requester valid.
- i_tready  out  NUM_REQ  per-requester ready, combinational from state and i_tvalid.
- set_stb  out  1  registered write strobe.
- set_addr  out  AWIDTH  registered address.
- set_data  out  32  registered data.
- set_src  out  $clog2(NUM_REQ)  registered index of the source of the current write.
- busy  out  1  high while in LOCKED.
- timeout_stb  out  1  one-cycle pulse on a watchdog release.

## Operation
- States: IDLE and LOCKED. Registers: state, owner, rr_ptr (last granted), set_* outputs and the watchdog counter.
- IDLE, at least one i_tvalid high:
  - Grant the first valid requester searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - Assert i_tready[grant] in the same cycle; the beat is accepted.
  - Set rr_ptr to grant.
  - If the beat has i_tlast, stay IDLE. Otherwise set owner to grant and go to LOCKED.
- IDLE, no valid: all i_tready low.
- LOCKED:
  - i_tready[owner] = 1; all others 0.
  - Each accepted beat produces a write.
  - An accepted beat with i_tlast returns to IDLE. The next grant then starts after owner, so the owner cannot take two packets back-to-back while others wait.
- Every accepted beat registers: set_stb=1, set_addr, set_data, set_src = its index. With no accepted beat, set_stb=0 and addr/data/src hold their values.
- The bus has no backpressure. A requester holding tvalid gets one write per cycle.
- Single-beat packets (tlast on the first beat) never enter LOCKED.
- A reset mid-packet drops the lock. The partial packet's already-issued writes stand, and the owner's next beat is treated as a new packet.

## Timing
- Reset values: set_stb=0, set_addr=0, set_data=0, set_src=0, busy=0, timeout_stb=0, state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority), watchdog counter=0.
- Latency: a beat accepted in cycle N produces set_stb in cycle N+1.
- Throughput: 1 write per cycle, including across packet boundaries and grant changes.
- i_tready depends combinationally on i_tvalid in IDLE. Sources must not make i_tvalid depend on i_tready.
- busy rises the cycle after a non-last first beat is accepted. It falls the cycle after the tlast beat is accepted or after a timeout.

## Configuration
- SETTING_ARB_WATCHDOG_EN defined:
  - In LOCKED, the counter increments on each cycle where i_tvalid[owner] is low, and clears on each accepted beat.
  - When the counter reaches TIMEOUT, go to IDLE, clear the counter and pulse timeout_stb for one cycle. rr_ptr stays at owner.
  - If the owner's beat is accepted in the same cycle the counter would expire, the accept wins and there is no timeout.
- Not defined: the lock lasts until tlast, the counter is not built, and timeout_stb is tied 0.

## Structure
- Package setting_arb_pkg holds:
  - state enum {ST_IDLE, ST_LOCKED};
  - localparam-style width helpers (SRC_W = $clog2(NUM_REQ), BEAT_W = AWIDTH+32);
  - watchdog counter width constant (16).
- Sub-module setting_arb_rr_pick: combinational round-robin picker. Inputs: request vector and rr_ptr. Outputs: one-hot grant, grant index and any_req.

## Test plan
- Reset, then req0 and req2 each send a single beat with tlast (addr 0x10/data 0xA, addr 0x20/data 0xB) in the same cycle → set_stb on two consecutive cycles: first src=0 addr 0x10, then src=2 addr 0x20.
- req1 sends a 3-beat packet (0x30, 0x31, 0x32 last) while req3 is valid throughout → writes from src 1 for 3 consecutive cycles, then src 3; i_tready[3] stays 0 until req1's tlast is accepted.
- All 4 requesters continuously valid with single-beat packets → set_src sequence 0,1,2,3,0,… with set_stb high every cycle.
- Reset asserted while req2 is locked after its 1st beat → busy=0 and all outputs zero the next cycle; req0's pending beat is granted first after reset.
- Watchdog build with TIMEOUT=4: req1 sends a non-last beat, then drops tvalid → timeout_stb pulses exactly 4 cycles after the last accept, busy falls, and the waiting req2 is granted.
- Watchdog build: req1 re-asserts valid in the cycle the count would reach TIMEOUT → beat accepted, no timeout_stb, lock retained.
